rgb_pwm_capture: RTL and testbench
==================================

Name: rgb_pwm_capture

Overview:
Three-channel PWM decoder, the receive-side counterpart of the team's RGB LED sweep driver. It samples the active-low RGB drive lines and measures, per channel, the period and the active (on) time of each PWM cycle. It also detects lines that are held static (fully on or fully off). It is used for closed-loop self-test of the LED sweep and for logging brightness profiles.

Parameters:
CNT_W, 16, width of the period and on-time counters and output fields.
TIMEOUT, 4095, cycles without a start edge before a channel is declared static; must be less than 2^CNT_W.
SYNC_STAGES, 2, input synchronizer depth (minimum 2).
ACTIVE_LOW, 1, 1 = line active (LED on) when low, 0 = active when high.

Ports:
clk  in  1  system clock (12 MHz on the target board)
rst_n  in  1  synchronous active-low reset
pwm_in  in  3  sampled PWM lines; bit0 = R, bit1 = G, bit2 = B; asynchronous to clk
on_cnt  out  3*CNT_W  per-channel active cycles of the last completed period; channel i occupies [i*CNT_W +: CNT_W]
period_cnt  out  3*CNT_W  per-channel total cycles of the last completed period; same packing as on_cnt
meas_valid  out  3  per-channel one-cycle strobe; high on the cycle on_cnt/period_cnt/is_static update
is_static  out  3  per-channel flag; 1 = no start edge seen within TIMEOUT
static_lvl  out  3  per-channel active level while is_static = 1 (1 = held on); 0 when not static

Behaviour:
- Clock and reset: single clock domain. rst_n is sampled only on the rising edge of clk.
- Reset values: all outputs 0. Synchronizer flops reset to the inactive level (1 when ACTIVE_LOW = 1). State is IDLE and accumulators are 0.
- Input conditioning:
  - Each line passes through SYNC_STAGES flops.
  - act = synchronized value XOR ACTIVE_LOW, so act = 1 means the LED is on.
  - A start edge is a cycle where act = 1 and the previous act = 0.
- Channel independence: each channel has its own FSM and counters. Simultaneous events on different channels are handled independently, in the same cycle.
- FSM per channel: IDLE, MEASURE, STATIC.
  - IDLE:
    - per_acc increments each cycle.
    - On a start edge: per_acc <= 1, on_acc <= 1, go to MEASURE. No meas_valid.
    - If per_acc reaches TIMEOUT: go to STATIC.
  - MEASURE:
    - Each cycle: per_acc + 1, and on_acc + act.
    - On a start edge: latch period_cnt <= per_acc and on_cnt <= on_acc, clear is_static and static_lvl, pulse meas_valid. In the same cycle reload per_acc = 1, on_acc = 1 and stay in MEASURE.
    - Result: for A active cycles followed by I inactive cycles, period_cnt = A+I and on_cnt = A.
    - If per_acc reaches TIMEOUT before a start edge: go to STATIC.
  - Entering STATIC:
    - on_cnt = 0, period_cnt = 0, is_static = 1, static_lvl = act.
    - Pulse meas_valid exactly once on entry.
  - STATIC:
    - static_lvl follows act every cycle, with no further meas_valid.
    - On a start edge: per_acc = 1, on_acc = 1, go to MEASURE. is_static stays 1 until the next completed period's meas_valid.
- Arithmetic: counters are unsigned CNT_W bits. The TIMEOUT check precedes any wrap, so counters never overflow.
- Latency: a pin transition reaches act after SYNC_STAGES cycles. meas_valid rises 1 cycle after act shows the start edge, so SYNC_STAGES+1 cycles after the pin edge.
- Minimum period: 2 cycles, because a start edge needs one inactive sample. Shorter pulses are filtered by sampling and are not an error.
- Simultaneous start edge and TIMEOUT on the same cycle: the start edge wins, the measurement is reported and the channel stays in MEASURE.
- Reset mid-operation: the partial period is discarded, all outputs drop to 0 on the next clock, and the channel returns to IDLE. The first valid after release needs two start edges, or TIMEOUT.

Test Plan:
1. Reset: rst_n low 3 cycles while pwm_in toggles -> all outputs 0 and meas_valid never asserts during reset.
2. R channel repeating 50 cycles low / 118 high (ACTIVE_LOW = 1) -> no valid on the first edge. Then meas_valid[0] pulses every 168 cycles with period_cnt = 168 and on_cnt = 50, and first pulse is SYNC_STAGES+1 cycles after the second falling pin edge.
3. G held high (off) from reset -> meas_valid[1] pulses once 4095 cycles after IDLE entry. is_static[1] = 1, static_lvl[1] = 0, on_cnt = 0, period_cnt = 0, and no further pulses for 10000 cycles.
4. B held low (on) past TIMEOUT, then 10 low / 20 high restarts -> static_lvl[2] = 1 while static. The first valid after restart gives 30/10 and clears is_static[2].
5. All three channels with an identical 10 low / 20 high waveform -> all three meas_valid bits pulse in the same cycle, each with period_cnt = 30 and on_cnt = 10.
6. rst_n pulsed low for 1 cycle mid-period on a 168/50 stream -> outputs clear. The next valid arrives only after two subsequent start edges and carries 168/50, with no truncated value.

Source files
------------

// File: rtl/rgb_pwm_capture.sv
// rgb_pwm_capture: per-channel PWM period/on-time decoder for the RGB drive lines,
// with static-line (held on/off) detection after TIMEOUT cycles without a start edge.
module rgb_pwm_capture #(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 4095,
    parameter int SYNC_STAGES = 2,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [2:0]         pwm_in_i,
    output logic [3*CNT_W-1:0] on_cnt_o,
    output logic [3*CNT_W-1:0] period_cnt_o,
    output logic [2:0]         meas_valid_o,
    output logic [2:0]         is_static_o,
    output logic [2:0]         static_lvl_o
);
    typedef enum logic [1:0] {IDLE, MEASURE, STATIC} state_t;

    localparam logic             IDLE_LVL = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] TMO_M1   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   act, prev_q, start, tmo;
        state_t                 state_q, state_d;
        logic [CNT_W-1:0]       per_q, per_d, on_q, on_d;
        logic [CNT_W-1:0]       per_out_q, per_out_d, on_out_q, on_out_d;
        logic                   valid_q, valid_d, stat_q, stat_d, lvl_q, lvl_d;

        assign act   = sync_q[SYNC_STAGES-1] ^ IDLE_LVL;
        assign start = act & ~prev_q;
        // Fires on the TIMEOUT-th cycle since the reference, before the counter could wrap
        assign tmo   = (per_q == TMO_M1);

        always_ff @(posedge clk_i) begin
            if (!rst_n_i) begin
                sync_q    <= {SYNC_STAGES{IDLE_LVL}};
                prev_q    <= 1'b0;
                state_q   <= IDLE;
                per_q     <= '0;
                on_q      <= '0;
                per_out_q <= '0;
                on_out_q  <= '0;
                valid_q   <= 1'b0;
                stat_q    <= 1'b0;
                lvl_q     <= 1'b0;
            end else begin
                sync_q    <= {sync_q[SYNC_STAGES-2:0], pwm_in_i[c]};
                prev_q    <= act;
                state_q   <= state_d;
                per_q     <= per_d;
                on_q      <= on_d;
                per_out_q <= per_out_d;
                on_out_q  <= on_out_d;
                valid_q   <= valid_d;
                stat_q    <= stat_d;
                lvl_q     <= lvl_d;
            end
        end

        always_comb begin
            state_d   = state_q;
            per_d     = per_q;
            on_d      = on_q;
            per_out_d = per_out_q;
            on_out_d  = on_out_q;
            valid_d   = 1'b0;
            stat_d    = stat_q;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        per_d   = ONE;
                        on_d    = ONE;
                        state_d = MEASURE;
                    end else if (tmo) begin
                        state_d   = STATIC;
                        valid_d   = 1'b1;
                        per_out_d = '0;
                        on_out_d  = '0;
                        stat_d    = 1'b1;
                    end else begin
                        per_d = per_q + ONE;
                    end
                end
                MEASURE: begin
                    if (start) begin
                        per_out_d = per_q;
                        on_out_d  = on_q;
                        stat_d    = 1'b0;
                        valid_d   = 1'b1;
                        per_d     = ONE;
                        on_d      = ONE;
                    end else if (tmo) begin
                        state_d   = STATIC;
                        valid_d   = 1'b1;
                        per_out_d = '0;
                        on_out_d  = '0;
                        stat_d    = 1'b1;
                    end else begin
                        per_d = per_q + ONE;
                        on_d  = on_q + {{(CNT_W-1){1'b0}}, act};
                    end
                end
                STATIC: begin
                    if (start) begin
                        per_d   = ONE;
                        on_d    = ONE;
                        state_d = MEASURE;
                    end
                end
                default: state_d = IDLE;
            endcase
            // The level tracks the line for as long as the static flag is held
            lvl_d = stat_d & act;
        end

        assign on_cnt_o[c*CNT_W +: CNT_W]     = on_out_q;
        assign period_cnt_o[c*CNT_W +: CNT_W] = per_out_q;
        assign meas_valid_o[c]                = valid_q;
        assign is_static_o[c]                 = stat_q;
        assign static_lvl_o[c]                = lvl_q;
    end
endmodule

// File: tb/tb_rgb_pwm_capture.sv
// tb_rgb_pwm_capture: directed PWM stimulus against a cycle-indexed behavioural model,
// plus hand-computed literal expectations for each scenario.
module tb_rgb_pwm_capture;
    localparam int W = 16;
    localparam int T = 4095;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [2:0]     pwm = 3'b111;
    logic [3*W-1:0] on_cnt, period_cnt;
    logic [2:0]     mv, st, lvl;

    int errors = 0;
    int checks = 0;
    int n = 0;

    always #5 clk = ~clk;

    rgb_pwm_capture #(.CNT_W(W), .TIMEOUT(T), .SYNC_STAGES(S), .ACTIVE_LOW(1)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .pwm_in_i(pwm),
        .on_cnt_o(on_cnt), .period_cnt_o(period_cnt),
        .meas_valid_o(mv), .is_static_o(st), .static_lvl_o(lvl)
    );

    // Model: act history per channel indexed by cycle; each channel is waiting (0),
    // measuring since a start edge (1) or static (2).
    bit         act_log [3][65536];
    int         mode [3];
    int         ref_t [3];
    bit         pa [3];
    logic [2:0] pq [S];
    logic [2:0] m_a;
    logic [W-1:0] e_on [3];
    logic [W-1:0] e_per [3];
    logic [2:0] e_v = '0, e_st = '0, e_lvl = '0;
    bit         armed = 0;

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            armed = 1;
            for (int i = 0; i < 3; i++) begin
                mode[i] = 0; ref_t[i] = n + 1; pa[i] = 0; e_on[i] = '0; e_per[i] = '0;
            end
            e_v = '0; e_st = '0; e_lvl = '0;
            for (int k = 0; k < S; k++) pq[k] = 3'b000;
        end else begin
            m_a = pq[S-1];
            e_v = '0;
            for (int i = 0; i < 3; i++) begin
                bit se;
                se = m_a[i] && !pa[i];
                act_log[i][n] = m_a[i];
                if (mode[i] != 2 && !se && (n - ref_t[i] + 1 == T)) begin
                    mode[i] = 2; e_v[i] = 1'b1; e_on[i] = '0; e_per[i] = '0; e_st[i] = 1'b1;
                end else if (se) begin
                    if (mode[i] == 1) begin
                        int s;
                        s = 0;
                        for (int j = ref_t[i]; j < n; j++) s += int'(act_log[i][j]);
                        e_v[i] = 1'b1; e_per[i] = W'(n - ref_t[i]); e_on[i] = W'(s); e_st[i] = 1'b0;
                    end
                    mode[i] = 1; ref_t[i] = n;
                end
                e_lvl[i] = e_st[i] & m_a[i];
                pa[i] = m_a[i];
            end
            for (int k = S - 1; k > 0; k--) pq[k] = pq[k-1];
            pq[0] = ~pwm;
        end
        n++;
    end

    initial forever begin
        @(negedge clk);
        if (armed) begin
            checks++;
            if ({on_cnt, period_cnt, mv, st, lvl} !==
                {e_on[2], e_on[1], e_on[0], e_per[2], e_per[1], e_per[0], e_v, e_st, e_lvl}) begin
                errors++;
                $display("FAIL model_cmp cycle %0d: dut on=%h per=%h v=%b st=%b lvl=%b, model on=%h%h%h per=%h%h%h v=%b st=%b lvl=%b",
                         n, on_cnt, period_cnt, mv, st, lvl, e_on[2], e_on[1], e_on[0],
                         e_per[2], e_per[1], e_per[0], e_v, e_st, e_lvl);
            end
        end
    end

    typedef struct {int ch; int t; logic [W-1:0] on; logic [W-1:0] per; logic st; logic lvl;} ev_t;
    ev_t evq[$];

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            if (mv[i] === 1'b1)
                evq.push_back('{i, n, on_cnt[i*W +: W], period_cnt[i*W +: W], st[i], lvl[i]});
    end

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic lit(input string nm, input longint got, input longint want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    function automatic int find(input int ch, input int from);
        foreach (evq[k]) if (evq[k].ch == ch && evq[k].t >= from) return k;
        return -1;
    endfunction

    function automatic int count(input int ch, input int from);
        int c;
        c = 0;
        foreach (evq[k]) if (evq[k].ch == ch && evq[k].t >= from) c++;
        return c;
    endfunction

    task automatic chk_ev(input string nm, input int ch, input int from, input int t,
                          input int per, input int on, input int stv, input int lv);
        int k;
        k = find(ch, from);
        if (k < 0) begin
            checks++; errors++;
            $display("FAIL %s: no meas_valid seen, expected one at cycle %0d", nm, t);
        end else begin
            lit({nm, "_time"}, evq[k].t, t);
            lit({nm, "_period"}, evq[k].per, per);
            lit({nm, "_on"}, evq[k].on, on);
            lit({nm, "_static"}, evq[k].st, stv);
            lit({nm, "_lvl"}, evq[k].lvl, lv);
        end
    endtask

    task automatic wave(input logic [2:0] m, input int lo, input int hi, input int periods);
        for (int p = 0; p < periods; p++) begin
            pwm = pwm & ~m;
            tick(lo);
            pwm = pwm | m;
            tick(hi);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int n0, t2, tb4, tb5, t5, t6, tr, trst;

    initial begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            pwm = ~pwm;
            tick(1);
            lit("rst_valid", mv, 0);
            lit("rst_outputs", {on_cnt, period_cnt, st, lvl} == '0, 1);
        end
        pwm = 3'b111;
        rst_n = 1'b1;
        n0 = n;

        // R: 50 on / 118 off, first report after the second falling edge
        tick(5);
        t2 = n;
        wave(3'b001, 50, 118, 5);
        tick(10);
        lit("r_count", count(0, n0), 4);
        for (int k = 0; k < 4; k++)
            chk_ev($sformatf("r_p%0d", k), 0, t2 + 171 + 168 * k, t2 + 171 + 168 * k, 168, 50, 0, 0);

        // B held on past TIMEOUT
        pwm[2] = 1'b0;
        tb4 = n;
        tick(4200);
        chk_ev("b_static", 2, tb4, tb4 + 2 + T, 0, 0, 1, 1);
        lit("b_lvl_held", lvl[2], 1);
        lit("b_is_static", st[2], 1);
        pwm[2] = 1'b1;
        tick(20);
        tb5 = n;
        wave(3'b100, 10, 20, 3);
        tick(5);
        chk_ev("b_restart", 2, tb5, tb5 + 33, 30, 10, 0, 0);

        // G held off since reset
        chk_ev("g_static", 1, n0, n0 + T, 0, 0, 1, 0);
        if (n < n0 + T + 10000) tick(n0 + T + 10000 - n);
        lit("g_single_pulse", count(1, n0), 1);

        // All three channels with the same waveform
        t5 = n;
        wave(3'b111, 10, 20, 4);
        tick(5);
        for (int i = 0; i < 3; i++) begin
            lit($sformatf("all_count%0d", i), count(i, t5), 3);
            chk_ev($sformatf("all_ch%0d", i), i, t5, t5 + 33, 30, 10, 0, 0);
        end

        // Reset pulse mid-period on the R stream
        t6 = n;
        wave(3'b001, 50, 118, 2);
        pwm[0] = 1'b0;
        tick(50);
        pwm[0] = 1'b1;
        tick(60);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        trst = n;
        lit("midrst_outputs", {on_cnt, period_cnt, mv, st, lvl} == '0, 1);
        tick(57);
        tr = n;
        wave(3'b001, 50, 118, 3);
        tick(5);
        chk_ev("r_after_rst", 0, trst, tr + 171, 168, 50, 0, 0);
        lit("r_after_rst_count", count(0, trst), 2);

        tick(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
